// File: rtl/bram_axis_streamer.sv
// bram_axis_streamer
//   Reads num consecutive words from a BRAM starting at base_addr (address
//   wraps modulo 2^ADDR_W) and streams them out on an AXI-Stream master.
//   Reads are credit-limited so the RD_LAT+2 deep output FIFO can never
//   overflow, whatever the m_axis_tready pattern.
//
// Optional feature: define BRAM_AXIS_STREAMER_SOF_EN to add m_axis_tuser,
//   a start-of-frame flag that is high on beat 0 of each transfer.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, base_addr, num   transfer request (base/num sampled with start)
//   bram_en, bram_addr, bram_dout   BRAM read port, RD_LAT cycle latency
//   m_axis_tdata/tvalid/tready/tlast   stream output
//   m_axis_tuser      (only with BRAM_AXIS_STREAMER_SOF_EN) first-beat flag
//   busy              transfer in progress, through the done cycle
//   done              one-cycle completion pulse
module bram_axis_streamer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
`ifdef BRAM_AXIS_STREAMER_SOF_EN
  ,
  output logic              m_axis_tuser
`endif
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    num_q, num_d;
  logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]   fifo_q [DEPTH];
  logic [DATA_W-1:0]   fifo_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [CNT_W:0]      occ;
  logic                arrive, fifo_empty, tvalid_int, hs, is_last;
  logic                rd_issue, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight plus words already buffered; a new read is only issued
  // while this is below the FIFO depth, so every returning word has a slot.
  always_comb begin
    occ = {1'b0, cnt_q};
    for (int i = 0; i < RD_LAT; i++) occ = occ + (CNT_W+1)'(rd_pipe_q[i]);
  end

  // A word arriving from the BRAM this cycle is presented directly when the
  // FIFO is empty, so the first beat appears RD_LAT+1 cycles after start.
  // If it is not taken it lands in the FIFO and stays at the head.
  assign arrive     = rd_pipe_q[RD_LAT-1];
  assign fifo_empty = (cnt_q == '0);
  assign tvalid_int = !fifo_empty || arrive;
  assign hs         = tvalid_int && m_axis_tready;
  assign is_last    = (beat_cnt_q == num_q - LEN_ONE);
  assign rd_issue   = (state_q == RUN) && (occ < (CNT_W+1)'(DEPTH));
  assign push       = arrive && !(fifo_empty && hs);
  assign pop        = hs && !fifo_empty;

  // read-valid shift register: bit RD_LAT-1 marks a word on bram_dout
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_issue;
    for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bram_dout;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    num_d      = num_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    if (hs) beat_cnt_d = beat_cnt_q + LEN_ONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num != '0) begin
            state_d    = RUN;
            addr_d     = base_addr;
            num_d      = num;
            rd_cnt_d   = '0;
            beat_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_issue) begin
          addr_d   = addr_q + 1'b1;
          rd_cnt_d = rd_cnt_q + LEN_ONE;
          if (rd_cnt_q == num_q - LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && is_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      num_q      <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      rd_pipe_q  <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      rd_pipe_q  <= rd_pipe_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bram_en       = rd_issue;
  assign bram_addr     = addr_q;
  assign m_axis_tvalid = tvalid_int;
  assign m_axis_tdata  = tvalid_int ? (fifo_empty ? bram_dout : fifo_q[rd_ptr_q]) : '0;
  assign m_axis_tlast  = tvalid_int && is_last;
  // done_q keeps busy high through the completion cycle
  assign busy          = (state_q != IDLE) || done_q;
  assign done          = done_q;
`ifdef BRAM_AXIS_STREAMER_SOF_EN
  assign m_axis_tuser  = tvalid_int && (beat_cnt_q == '0);
`endif

endmodule

// File: tb/tb_bram_axis_streamer.sv
// Bench for bram_axis_streamer: two instances (RD_LAT=1 and RD_LAT=3) run
// the same stimulus in lockstep, each with its own BRAM model and its own
// transaction-level reference (expected beat i = mem[base+i]).
module tb_bram_axis_streamer;
  localparam int DW = 64;
  localparam int AW = 14;
  localparam int LW = 14;

  logic clk = 1'b0;
  logic rst, start, tready;
  logic [AW-1:0] base;
  logic [LW-1:0] num;

  logic          en     [2];
  logic [AW-1:0] addr   [2];
  logic [DW-1:0] dout   [2];
  logic [DW-1:0] tdata  [2];
  logic          tvalid [2];
  logic          tlast  [2];
  logic          busy   [2];
  logic          done   [2];
`ifdef BRAM_AXIS_STREAMER_SOF_EN
  logic          tuser  [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return {16'hBEEF, 2'b00, a, 16'h1234, 2'b00, ~a};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_bram
    localparam int LAT = (k == 0) ? 1 : 3;
    logic [DW-1:0] stg [LAT];
    always @(posedge clk) begin
      if (en[k]) stg[0] <= memval(addr[k]);
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
    assign dout[k] = stg[LAT-1];
  end

  bram_axis_streamer #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .num(num),
    .bram_en(en[0]), .bram_addr(addr[0]), .bram_dout(dout[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready),
    .m_axis_tlast(tlast[0]), .busy(busy[0]), .done(done[0])
`ifdef BRAM_AXIS_STREAMER_SOF_EN
    , .m_axis_tuser(tuser[0])
`endif
  );

  bram_axis_streamer #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .num(num),
    .bram_en(en[1]), .bram_addr(addr[1]), .bram_dout(dout[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready),
    .m_axis_tlast(tlast[1]), .busy(busy[1]), .done(done[1])
`ifdef BRAM_AXIS_STREAMER_SOF_EN
    , .m_axis_tuser(tuser[1])
`endif
  );

  // reference state per instance
  bit            active   [2];
  bit            done_exp [2];
  bit            stall    [2];
  logic [AW-1:0] m_base   [2];
  int            m_num    [2];
  int            m_beat   [2];
  int            m_issue  [2];
  int            start_cyc[2];
  int            first_cyc[2];
  int            last_cyc [2];
  int            done_cnt [2];
  int            beats_last[2];
  logic [DW-1:0] prev_data[2];
  logic [DW-1:0] cap  [2][16];
  logic [AW-1:0] alog [2][16];

  task automatic chk(input bit ok, input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst%0d actual %h required %h", nm, k, act, req);
    end
  endtask

  always @(negedge clk) begin
    bit hs, nd, was_act;
    int occ;
    logic [DW-1:0] ev;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk(!en[k] && !tvalid[k] && !tlast[k] && !busy[k] && !done[k], "rst_ctl", k,
            {59'd0, en[k], tvalid[k], tlast[k], busy[k], done[k]}, 64'd0);
        chk(addr[k] == '0 && tdata[k] == '0, "rst_data", k, tdata[k] | 64'(addr[k]), 64'd0);
`ifdef BRAM_AXIS_STREAMER_SOF_EN
        chk(!tuser[k], "rst_tuser", k, 64'(tuser[k]), 64'd0);
`endif
        active[k] = 0; done_exp[k] = 0; stall[k] = 0;
      end else begin
        was_act = active[k];
        nd = 0;
        chk(done[k] == done_exp[k], "done", k, 64'(done[k]), 64'(done_exp[k]));
        chk(busy[k] == (active[k] || done_exp[k]), "busy", k, 64'(busy[k]),
            64'(active[k] || done_exp[k]));
        occ = (k == 0) ? int'(u0.cnt_q) : int'(u1.cnt_q);
        chk(occ <= ((k == 0) ? 3 : 5), "fifo_ovf", k, 64'(occ), 64'((k == 0) ? 3 : 5));
        if (en[k]) begin
          chk(active[k] && m_issue[k] < m_num[k], "en_legal", k, 64'(m_issue[k]), 64'(m_num[k]));
          chk(addr[k] == AW'(m_base[k] + m_issue[k]), "rd_addr", k, 64'(addr[k]),
              64'(AW'(m_base[k] + m_issue[k])));
          if (m_issue[k] < 16) alog[k][m_issue[k]] = addr[k];
          m_issue[k]++;
        end
        if (stall[k])
          chk(tvalid[k] && tdata[k] == prev_data[k], "stable", k, tdata[k], prev_data[k]);
        if (tvalid[k]) begin
          chk(active[k] && m_beat[k] < m_num[k], "tvalid_legal", k, 64'(m_beat[k]), 64'(m_num[k]));
          ev = memval(AW'(m_base[k] + m_beat[k]));
          chk(tdata[k] == ev, "tdata", k, tdata[k], ev);
          chk(tlast[k] == (m_beat[k] == m_num[k] - 1), "tlast", k, 64'(tlast[k]),
              64'(m_beat[k] == m_num[k] - 1));
`ifdef BRAM_AXIS_STREAMER_SOF_EN
          chk(tuser[k] == (m_beat[k] == 0), "tuser", k, 64'(tuser[k]), 64'(m_beat[k] == 0));
`endif
          if (m_beat[k] == 0 && !stall[k]) first_cyc[k] = cyc;
        end
        hs = tvalid[k] && tready;
        if (hs) begin
          if (m_beat[k] < 16) cap[k][m_beat[k]] = tdata[k];
          if (m_beat[k] == m_num[k] - 1) begin
            nd = 1; active[k] = 0; beats_last[k] = m_beat[k] + 1; last_cyc[k] = cyc;
          end
          m_beat[k]++;
        end
        stall[k] = tvalid[k] && !tready;
        prev_data[k] = tdata[k];
        if (start && !was_act) begin
          if (num != '0) begin
            active[k] = 1; m_base[k] = base; m_num[k] = int'(num);
            m_beat[k] = 0; m_issue[k] = 0; start_cyc[k] = cyc;
          end else begin
            nd = 1;
          end
        end
        if (done_exp[k]) done_cnt[k]++;
        done_exp[k] = nd;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [LW-1:0] n);
    beats_last[0] = 0; beats_last[1] = 0;
    base = b; num = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: hold tready, 1: random, 2: toggle every cycle
  task automatic wait_idle(input int mode, input int bound);
    int n = 0;
    do begin
      if (mode == 1) tready = 1'($urandom_range(0, 1));
      else if (mode == 2) tready = ~tready;
      step();
      n++;
    end while (!(!active[0] && !active[1] && !done_exp[0] && !done_exp[1]) && n < bound);
    chk(n < bound, "timeout_idle", 0, 64'(n), 64'(bound));
    tready = 1'b1;
  endtask

  initial begin
    int d0, n;
    rst = 1'b1; start = 1'b0; tready = 1'b1; base = '0; num = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // long burst, tready held high
    go(14'd0, 14'd768);
    wait_idle(0, 3000);
    for (int k = 0; k < 2; k++) begin
      chk(beats_last[k] == 768, "t1_beats", k, 64'(beats_last[k]), 64'd768);
      chk(last_cyc[k] - first_cyc[k] == 767, "t1_nogap", k,
          64'(last_cyc[k] - first_cyc[k]), 64'd767);
    end
    chk(first_cyc[0] - start_cyc[0] == 2, "t1_lat1", 0, 64'(first_cyc[0] - start_cyc[0]), 64'd2);
    chk(first_cyc[1] - start_cyc[1] == 4, "t1_lat3", 1, 64'(first_cyc[1] - start_cyc[1]), 64'd4);

    // long burst with random backpressure
    go(14'd0, 14'd768);
    wait_idle(1, 6000);
    for (int k = 0; k < 2; k++)
      chk(beats_last[k] == 768, "t2_beats", k, 64'(beats_last[k]), 64'd768);

    // address wrap past the top
    go(14'd16380, 14'd8);
    wait_idle(0, 200);
    for (int k = 0; k < 2; k++) begin
      chk(cap[k][0] == 64'hBEEF_3FFC_1234_0003, "t3_d0", k, cap[k][0], 64'hBEEF_3FFC_1234_0003);
      chk(cap[k][4] == 64'hBEEF_0000_1234_3FFF, "t3_d4", k, cap[k][4], 64'hBEEF_0000_1234_3FFF);
      chk(alog[k][3] == 14'd16383, "t3_a3", k, 64'(alog[k][3]), 64'd16383);
      chk(alog[k][7] == 14'd3, "t3_a7", k, 64'(alog[k][7]), 64'd3);
    end

    // zero-length request, then a start ignored while busy
    d0 = done_cnt[0];
    go(14'd5, 14'd0);
    wait_idle(0, 20);
    chk(done_cnt[0] == d0 + 1, "t4_done0", 0, 64'(done_cnt[0]), 64'(d0 + 1));
    d0 = done_cnt[0];
    go(14'd20, 14'd4);
    step(); step();
    base = 14'd50; num = 14'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(0, 100);
    chk(done_cnt[0] == d0 + 1, "t4_done1", 0, 64'(done_cnt[0]), 64'(d0 + 1));
    for (int k = 0; k < 2; k++) begin
      chk(beats_last[k] == 4, "t4_beats", k, 64'(beats_last[k]), 64'd4);
      chk(cap[k][3] == 64'hBEEF_0017_1234_3FE8, "t4_d3", k, cap[k][3], 64'hBEEF_0017_1234_3FE8);
    end

    // reset mid-transfer, then a short clean transfer
    go(14'd0, 14'd768);
    n = 0;
    while (m_beat[0] < 100 && n < 1000) begin step(); n++; end
    chk(n < 1000, "timeout_b100", 0, 64'(n), 64'd1000);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    go(14'd0, 14'd4);
    wait_idle(0, 100);
    for (int k = 0; k < 2; k++) begin
      chk(beats_last[k] == 4, "t5_beats", k, 64'(beats_last[k]), 64'd4);
      chk(cap[k][0] == 64'hBEEF_0000_1234_3FFF, "t5_d0", k, cap[k][0], 64'hBEEF_0000_1234_3FFF);
      chk(cap[k][3] == 64'hBEEF_0003_1234_3FFC, "t5_d3", k, cap[k][3], 64'hBEEF_0003_1234_3FFC);
    end

    // tready toggling every cycle
    go(14'd7, 14'd5);
    wait_idle(2, 200);
    for (int k = 0; k < 2; k++) begin
      chk(beats_last[k] == 5, "t6_beats", k, 64'(beats_last[k]), 64'd5);
      chk(cap[k][0] == 64'hBEEF_0007_1234_3FF8, "t6_d0", k, cap[k][0], 64'hBEEF_0007_1234_3FF8);
      chk(cap[k][4] == 64'hBEEF_000B_1234_3FF4, "t6_d4", k, cap[k][4], 64'hBEEF_000B_1234_3FF4);
    end

    // start in the done cycle of the fast instance is accepted there and
    // ignored by the slower one, still mid-transfer
    go(14'd200, 14'd6);
    n = 0;
    while (!done[0] && n < 100) begin step(); n++; end
    chk(n < 100, "timeout_done", 0, 64'(n), 64'd100);
    base = 14'd100; num = 14'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(0, 100);
    chk(beats_last[0] == 3, "t7_beats0", 0, 64'(beats_last[0]), 64'd3);
    chk(cap[0][0] == 64'hBEEF_0064_1234_3F9B, "t7_d0", 0, cap[0][0], 64'hBEEF_0064_1234_3F9B);
    chk(beats_last[1] == 6, "t7_beats1", 1, 64'(beats_last[1]), 64'd6);

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
